// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock, {HI, LO} = {rem, quot}.
// Optional macro DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  annul,
    input  logic                  signed_div,
    input  logic [DATA_W-1:0]     opdata1,
    input  logic [DATA_W-1:0]     opdata2,
    output logic [2*DATA_W-1:0]   result,
    output logic                  ready
);

    localparam logic [2:0] FREE    = 3'd0;
    localparam logic [2:0] BY_ZERO = 3'd1;
    localparam logic [2:0] ON      = 3'd2;
    localparam logic [2:0] END     = 3'd3;
`ifdef DIV_EARLY_OUT_EN
    localparam logic [2:0] EARLY   = 3'd4;
`endif

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     dvd_q, dvd_d;
    logic [DATA_W-1:0]     dvs_q, dvs_d;
    logic [DATA_W-1:0]     rem_q, rem_d;
    logic                  sign1_q, sign1_d;
    logic                  sign2_q, sign2_d;
    logic [2*DATA_W-1:0]   result_q, result_d;

    logic [DATA_W-1:0]     abs1, abs2;
    logic [DATA_W:0]       shifted, diff;
    logic [DATA_W-1:0]     quot_fix, rem_fix;

    always_comb begin
        abs1 = (signed_div && opdata1[DATA_W-1]) ? -opdata1 : opdata1;
        abs2 = (signed_div && opdata2[DATA_W-1]) ? -opdata2 : opdata2;
        // Quotient bits shift into dvd_q as the dividend bits shift out.
        shifted  = {rem_q, dvd_q[DATA_W-1]};
        diff     = shifted - {1'b0, dvs_q};
        quot_fix = (sign1_q ^ sign2_q) ? -dvd_q : dvd_q;
        rem_fix  = sign1_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        result_d = result_q;
        case (state_q)
            FREE: begin
                if (start && !annul) begin
                    if (opdata2 == '0) begin
                        state_d = BY_ZERO;
`ifdef DIV_EARLY_OUT_EN
                    end else if (abs1 < abs2) begin
                        state_d = EARLY;
                        dvd_d   = opdata1;
`endif
                    end else begin
                        state_d = ON;
                        dvd_d   = abs1;
                        dvs_d   = abs2;
                        sign1_d = signed_div & opdata1[DATA_W-1];
                        sign2_d = signed_div & opdata2[DATA_W-1];
                        rem_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            BY_ZERO: begin
                if (annul) begin
                    state_d = FREE;
                end else begin
                    state_d  = END;
                    result_d = '0;
                end
            end
`ifdef DIV_EARLY_OUT_EN
            EARLY: begin
                if (annul) begin
                    state_d = FREE;
                end else begin
                    state_d  = END;
                    result_d = {dvd_q, {DATA_W{1'b0}}};
                end
            end
`endif
            ON: begin
                if (annul) begin
                    state_d = FREE;
                end else if (cnt_q == CNT_W'(DATA_W)) begin
                    state_d  = END;
                    result_d = {rem_fix, quot_fix};
                end else begin
                    if (!diff[DATA_W]) begin
                        rem_d = diff[DATA_W-1:0];
                    end else begin
                        rem_d = shifted[DATA_W-1:0];
                    end
                    dvd_d = {dvd_q[DATA_W-2:0], ~diff[DATA_W]};
                    cnt_d = cnt_q + 1'b1;
                end
            end
            END: begin
                if (!start) begin
                    state_d = FREE;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FREE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign ready  = (state_q == END);

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; honours DIV_EARLY_OUT_EN for early-out latency.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] opdata1 = '0;
    logic [31:0] opdata2 = '0;
    logic [63:0] result;
    logic        ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .annul      (annul),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .result     (result),
        .ready      (ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accepts at E0, scrambles operands, returns edges after E0 until ready (-1 on timeout).
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        signed_div = sgn;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        lat        = -1;
        step();
        opdata1 = $urandom;
        opdata2 = $urandom;
        for (int n = 1; n <= 100; n++) begin
            step();
            if (ready) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release_op();
        start = 1'b0;
        step();
    endtask

    task automatic test_reset();
        int lat;
        rst = 1'b1;
        step();
        step();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", ready);
        end
        checks++;
        if (result !== 64'h0) begin
            errors++;
            $display("FAIL reset_result: got %h want 0", result);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_divu();
        int lat;
        run_op(1'b0, 32'd100, 32'd7, lat);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL divu_100_7_latency: got %0d want 33", lat);
        end
        checks++;
        if (result !== 64'h00000002_0000000E) begin
            errors++;
            $display("FAIL divu_100_7_result: got %h want 000000020000000e", result);
        end
        release_op();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL divu_release_ready: got %b want 0", ready);
        end
    endtask

    task automatic test_signed();
        int lat;
        run_op(1'b1, 32'hFFFFFFF9, 32'h00000002, lat);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL div_m7_2_latency: got %0d want 33", lat);
        end
        checks++;
        if (result !== 64'hFFFFFFFF_FFFFFFFD) begin
            errors++;
            $display("FAIL div_m7_2_result: got %h want fffffffffffffffd", result);
        end
        release_op();
        run_op(1'b0, 32'hFFFFFFF9, 32'h00000002, lat);
        checks++;
        if (result !== 64'h00000001_7FFFFFFC) begin
            errors++;
            $display("FAIL divu_fff9_2_result: got %h want 000000017ffffffc", result);
        end
        release_op();
        run_op(1'b1, 32'h00000007, 32'hFFFFFFFE, lat);
        checks++;
        if (result !== 64'h00000001_FFFFFFFD) begin
            errors++;
            $display("FAIL div_7_m2_result: got %h want 00000001fffffffd", result);
        end
        release_op();
    endtask

    task automatic test_div_zero();
        int lat;
        run_op(1'b1, 32'd5, 32'd0, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL div_by_zero_latency: got %0d want 1", lat);
        end
        checks++;
        if (result !== 64'h0) begin
            errors++;
            $display("FAIL div_by_zero_result: got %h want 0", result);
        end
        release_op();
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, lat);
        checks++;
        if (result !== 64'h00000000_80000000) begin
            errors++;
            $display("FAIL div_overflow_result: got %h want 0000000080000000", result);
        end
        release_op();
    endtask

    task automatic test_annul();
        int  lat;
        logic seen = 1'b0;
        signed_div = 1'b0;
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        start      = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            seen |= ready;
        end
        annul = 1'b1;
        step();
        start = 1'b0;
        annul = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            seen |= ready;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL annul_ready: got %b want 0", seen);
        end
        checks++;
        if (result !== 64'h00000000_80000000) begin
            errors++;
            $display("FAIL annul_result_kept: got %h want 0000000080000000", result);
        end
        // annul wins over start in FREE: a divide-by-zero would otherwise finish in one edge.
        opdata1 = 32'd5;
        opdata2 = 32'd0;
        start   = 1'b1;
        annul   = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen |= ready;
        end
        start = 1'b0;
        annul = 1'b0;
        step();
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL annul_priority_ready: got %b want 0", seen);
        end
        run_op(1'b0, 32'd9, 32'd3, lat);
        checks++;
        if (lat !== 33 || result !== 64'h00000000_00000003) begin
            errors++;
            $display("FAIL after_annul_divu_9_3: got lat=%0d res=%h want lat=33 res=3", lat, result);
        end
        release_op();
    endtask

    task automatic test_reset_mid();
        signed_div = 1'b0;
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        start      = 1'b1;
        for (int i = 0; i < 20; i++) step();
        rst = 1'b1;
        step();
        checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid_op: got ready=%b res=%h want ready=0 res=0", ready, result);
        end
        rst   = 1'b0;
        start = 1'b0;
        step();
    endtask

    task automatic test_end_hold();
        int lat;
        run_op(1'b0, 32'd100, 32'd7, lat);
        for (int i = 0; i < 5; i++) begin
            opdata1 = 32'd50 + 32'(i);
            opdata2 = 32'd5;
            step();
            checks++;
            if (ready !== 1'b1 || result !== 64'h00000002_0000000E) begin
                errors++;
                $display("FAIL end_hold_%0d: got ready=%b res=%h want ready=1 res=000000020000000e",
                         i, ready, result);
            end
        end
        release_op();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL end_hold_release: got %b want 0", ready);
        end
    endtask

    task automatic test_early_out();
        int lat;
        int want_lat;
`ifdef DIV_EARLY_OUT_EN
        want_lat = 1;
`else
        want_lat = 33;
`endif
        run_op(1'b0, 32'd3, 32'd10, lat);
        checks++;
        if (lat !== want_lat) begin
            errors++;
            $display("FAIL divu_3_10_latency: got %0d want %0d", lat, want_lat);
        end
        checks++;
        if (result !== 64'h00000003_00000000) begin
            errors++;
            $display("FAIL divu_3_10_result: got %h want 0000000300000000", result);
        end
        release_op();
        run_op(1'b1, 32'hFFFFFFFD, 32'd10, lat);
        checks++;
        if (lat !== want_lat || result !== 64'hFFFFFFFD_00000000) begin
            errors++;
            $display("FAIL div_m3_10: got lat=%0d res=%h want lat=%0d res=fffffffd00000000",
                     lat, result, want_lat);
        end
        release_op();
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_end_hold();
        test_early_out();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative divider that services DIV/DIVU on behalf of the execute stage.
- Execute stage is the initiator: raises start with operands and holds them. This block responds with ready and a 64-bit {HI, LO} result for the hi/lo write path.
- One quotient bit per cycle (restoring division). The pipeline controller stalls upstream while start=1 and ready=0.

Parameters:
- DATA_W, 32, operand width. Result is 2*DATA_W. Only 32 is verified.
- CNT_W, 6, iteration counter width. Must hold DATA_W+1.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request; held high by initiator until it sees ready
- annul  input  1  abort in-flight op (pipeline flush)
- signed_div  input  1  1 = DIV (signed), 0 = DIVU
- opdata1  input  DATA_W  dividend; sampled only at accept
- opdata2  input  DATA_W  divisor; sampled only at accept
- result  output  2*DATA_W  [63:32] remainder (HI), [31:0] quotient (LO)
- ready  output  1  result valid

Behaviour:
- Reset: one clock and synchronous active-high reset, as already decided. rst=1 at an edge forces state FREE, cnt=0, ready=0, result=0, including mid-operation. Partial work is discarded.
- States: FREE, BY_ZERO, ON, END.
- FREE, start=1, annul=0:
  - Sample operands.
  - If opdata2==0, go to BY_ZERO.
  - Otherwise latch |opdata1| and |opdata2| when signed_div=1 (raw values when signed_div=0), record both sign bits, clear partial remainder, set cnt=0, go to ON.
  - This accept edge is E0.
- FREE with start=0 or annul=1: stay; ready=0.
- BY_ZERO: next edge goes to END with result=0.
- ON: each edge runs one restoring step.
  - Shift {rem, dividend} left 1; trial-subtract divisor.
  - If non-negative, keep the difference and set quotient bit 1; else quotient bit 0.
  - cnt increments.
  - Edges E1..E32 produce the 32 quotient bits.
  - Edge E33 (cnt==32): apply signs and go to END.
- Sign rules (signed_div=1):
  - Quotient is negated iff operand signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0 (natural wrap, no trap).
  - Unsigned ops ignore sign bits.
- END: ready=1 and result held stable.
  - Stays in END while start=1.
  - start=0 at an edge returns to FREE; ready=0 after that edge.
  - The initiator must drop start for at least one cycle between ops.
- Latency: ready is first visible after E33, i.e. 33 cycles after accept. Divide-by-zero: visible after E1.
- annul:
  - annul=1 in ON or BY_ZERO returns to FREE at the next edge; ready stays 0; result unchanged.
  - annul in END is ignored. END exits only on start=0.
  - annul has priority over start in FREE.
- Operand changes after accept are ignored.
- result is only updated on entry to END.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in FREE, with a nonzero divisor where magnitude(dividend) < magnitude(divisor), the block goes to BY_ZERO-like state EARLY. Next edge goes to END with quotient=0 and remainder=original opdata1 (sign preserved). ready is visible after E1.
- Not defined: such operands take the full 33-cycle ON path, with identical numeric results.

Test Plan:
- DIVU 100/7: start=1 held → ready rises after E33, result=0x00000002_0000000E. start=0 → ready=0 next cycle.
- DIV -7/2 (0xFFFFFFF9, 0x00000002): → result=0xFFFFFFFF_FFFFFFFD after 33 cycles. Same operands as DIVU → q=0x7FFFFFFC, r=0x00000001.
- DIV 5/0: → ready after E1, result=0. DIV 0x80000000/0xFFFFFFFF → result=0x00000000_80000000.
- annul=1 at E10 of DIVU 100/7: → FREE, ready never rises. The next DIVU 9/3 completes normally with result=0x00000000_00000003.
- rst=1 at E20 mid-operation: → ready=0, result=0 next cycle. Hold start high in END for 5 cycles → result stable, no re-accept until start drops.
- DIVU 3/10: with DIV_EARLY_OUT_EN → ready after E1, result=0x00000003_00000000. Without it → same result after E33.
